// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the byte-serial memory controller.
//   state_e    controller sequencing states
//   owner_e    which CPU port owns the current transaction
//   SIZE_*     ls_size_in encodings; size_bytes() maps an encoding to its byte count
package mem_ctrl_pkg;

  localparam int ADDR_WIDTH_DFLT = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // 2'b11 is deliberately folded into the word case.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundle of the CPU-side request ports and the RAM pins of mem_ctrl.
//   slave  : the controller side (takes requests and RAM read data, drives done/data and RAM pins)
//   master : the core/RAM side (drives requests and RAM read data)
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  flush_in;
  logic                  if_req_in;
  logic [ADDR_WIDTH-1:0] if_addr_in;
  logic                  if_done_out;
  logic [31:0]           if_data_out;
  logic                  ls_req_in;
  logic                  ls_we_in;
  logic [1:0]            ls_size_in;
  logic [ADDR_WIDTH-1:0] ls_addr_in;
  logic [31:0]           ls_wdata_in;
  logic                  ls_done_out;
  logic [31:0]           ls_rdata_out;
  logic                  ram_en_out;
  logic                  ram_r_nw_out;
  logic [ADDR_WIDTH-1:0] ram_a_out;
  logic [7:0]            ram_d_out;
  logic [7:0]            ram_d_in;

  modport slave (
    input  flush_in, if_req_in, if_addr_in, ls_req_in, ls_we_in, ls_size_in,
           ls_addr_in, ls_wdata_in, ram_d_in,
    output if_done_out, if_data_out, ls_done_out, ls_rdata_out,
           ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out
  );

  modport master (
    output flush_in, if_req_in, if_addr_in, ls_req_in, ls_we_in, ls_size_in,
           ls_addr_in, ls_wdata_in, ram_d_in,
    input  if_done_out, if_data_out, ls_done_out, ls_rdata_out,
           ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out
  );
endinterface

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: grant selection between the IF and LS ports.
//   clk_in, rst_n_in  clock, async active-low reset
//   sample_in         controller is idle; requests are only looked at then
//   if_req_in         IF request (already masked by flush)
//   ls_req_in         LS request
//   grant_out         a request is granted this cycle
//   grant_owner_out   port being granted
//   last_owner_out    last granted port (owner of the current transaction), IF after reset
// Macro MEM_CTRL_RR_EN: round-robin between simultaneous requests; otherwise LS always wins.
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst_n_in,
  input  logic   sample_in,
  input  logic   if_req_in,
  input  logic   ls_req_in,
  output logic   grant_out,
  output owner_e grant_owner_out,
  output owner_e last_owner_out
);

  owner_e last_owner_q, last_owner_d;

  always_comb begin
    grant_out       = sample_in & (if_req_in | ls_req_in);
    grant_owner_out = OWN_LS;
    if (if_req_in && ls_req_in) begin
`ifdef MEM_CTRL_RR_EN
      grant_owner_out = (last_owner_q == OWN_LS) ? OWN_IF : OWN_LS;
`else
      grant_owner_out = OWN_LS;
`endif
    end else if (if_req_in) begin
      grant_owner_out = OWN_IF;
    end
    last_owner_d = grant_out ? grant_owner_out : last_owner_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) last_owner_q <= OWN_IF;
    else           last_owner_q <= last_owner_d;
  end

  assign last_owner_out = last_owner_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller between the CPU IF/LS ports and an 8-bit synchronous RAM.
//   clk_in    system clock
//   rst_n_in  asynchronous active-low reset
//   bus       mem_ctrl_if.slave: IF/LS request ports, done/data outputs, RAM pins
// Macro MEM_CTRL_RR_EN (handled in mem_ctrl_arb): round-robin arbitration.
//
// state  | meaning
// IDLE   | sample requests, grant one
// ACCESS | one RAM byte per cycle, idx 0..N-1
// WAIT   | reads only: collect the last byte from the RAM
// DONE   | owner's done pulse, then back to IDLE
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  mem_ctrl_if.slave bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            idx_q, idx_d, last_idx_q, last_idx_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d, result_q, result_d;
  logic [31:0]           if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;
  logic                  if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic                  grant, abort, sample, if_req_ok;
  owner_e                grant_owner, owner;

  assign sample    = (state_q == IDLE);
  assign if_req_ok = bus.if_req_in & ~bus.flush_in;
  // A flush kills an IF transaction the same cycle it is seen.
  assign abort     = bus.flush_in & (owner == OWN_IF) &
                     ((state_q == ACCESS) | (state_q == WAIT));

  mem_ctrl_arb u_arb (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .sample_in       (sample),
    .if_req_in       (if_req_ok),
    .ls_req_in       (bus.ls_req_in),
    .grant_out       (grant),
    .grant_owner_out (grant_owner),
    .last_owner_out  (owner)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    result_d   = result_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = ACCESS;
          idx_d    = 2'd0;
          result_d = '0;
          if (grant_owner == OWN_LS) begin
            addr_d     = bus.ls_addr_in;
            we_d       = bus.ls_we_in;
            wdata_d    = bus.ls_wdata_in;
            last_idx_d = 2'(size_bytes(bus.ls_size_in) - 3'd1);
          end else begin
            addr_d     = bus.if_addr_in;
            we_d       = 1'b0;
            wdata_d    = '0;
            last_idx_d = 2'd3;
          end
        end
      end
      ACCESS: begin
        // RAM read data lags the address by one cycle.
        if (!we_q && idx_q != 2'd0) result_d[{idx_q - 2'd1, 3'b000} +: 8] = bus.ram_d_in;
        if (idx_q == last_idx_q) begin
          if (we_q) begin
            state_d   = DONE;
            ls_done_d = (owner == OWN_LS);
            if_done_d = (owner == OWN_IF);
          end else begin
            state_d = WAIT;
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      WAIT: begin
        result_d[{last_idx_q, 3'b000} +: 8] = bus.ram_d_in;
        state_d = DONE;
        if (owner == OWN_LS) begin
          ls_rdata_d = result_d;
          ls_done_d  = 1'b1;
        end else begin
          if_data_d = result_d;
          if_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      if_done_d = 1'b0;
      if_data_d = if_data_q;
      result_d  = result_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      result_q   <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      result_q   <= result_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
    end
  end

  // RAM pins decode straight from the state flops so reset and flush act within the cycle.
  always_comb begin
    bus.ram_en_out   = 1'b0;
    bus.ram_r_nw_out = 1'b1;
    bus.ram_a_out    = '0;
    bus.ram_d_out    = '0;
    if (state_q == ACCESS) begin
      bus.ram_en_out   = ~abort;
      bus.ram_r_nw_out = ~we_q;
      bus.ram_a_out    = addr_q + ADDR_WIDTH'(idx_q);
      if (we_q) bus.ram_d_out = wdata_q[{idx_q, 3'b000} +: 8];
    end else if (state_q == WAIT) begin
      bus.ram_en_out = ~abort;
      bus.ram_a_out  = addr_q + ADDR_WIDTH'(last_idx_q);
    end
  end

  assign bus.if_done_out  = if_done_q;
  assign bus.if_data_out  = if_data_q;
  assign bus.ls_done_out  = ls_done_q;
  assign bus.ls_rdata_out = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl with a behavioural RAM and a shadow-memory model.
module tb_mem_ctrl;

  localparam logic [16:0] AMASK = 17'h1FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_ctrl_if bus ();

  mem_ctrl dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));

  logic [7:0]  ram    [0:131071];
  logic [7:0]  shadow [0:131071];
  logic [7:0]  rd_q;
  logic        poke_en = 1'b0;
  logic [16:0] poke_a  = '0;
  logic [7:0]  poke_d  = '0;

  // Synchronous RAM; read data is junk unless the previous cycle was an enabled read.
  always @(posedge clk) begin
    if (poke_en) ram[poke_a] <= poke_d;
    else if (bus.ram_en_out && !bus.ram_r_nw_out) ram[bus.ram_a_out] <= bus.ram_d_out;
    if (bus.ram_en_out && bus.ram_r_nw_out) rd_q <= ram[bus.ram_a_out];
    else rd_q <= 8'($urandom);
  end
  assign bus.ram_d_in = rd_q;

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [1:0]  size;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input bit is_ls, input logic [1:0] size);
    if (!is_ls) return 4;
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [16:0] addr, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(shadow[(addr + 17'(k)) & AMASK]) << (8 * k));
    return v;
  endfunction

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    shadow[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run_txn(input bit is_ls, input bit we, input logic [1:0] size,
                         input logic [16:0] addr, input logic [31:0] wd,
                         output logic [31:0] data);
    logic [16:0] alog[$];
    int n, lat, bad, exp_cnt;
    bit other;
    logic [16:0] ea;
    n = nbytes(is_ls, size);
    other = 0;
    @(negedge clk);
    if (is_ls) begin
      bus.ls_req_in = 1'b1; bus.ls_we_in = we; bus.ls_size_in = size;
      bus.ls_addr_in = addr; bus.ls_wdata_in = wd;
    end else begin
      bus.if_req_in = 1'b1; bus.if_addr_in = addr;
    end
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus.ram_en_out) alog.push_back(bus.ram_a_out);
      if (is_ls ? bus.if_done_out : bus.ls_done_out) other = 1;
      if ((is_ls ? bus.ls_done_out : bus.if_done_out) || lat >= 40) break;
    end
    data = is_ls ? bus.ls_rdata_out : bus.if_data_out;
    bus.ls_req_in = 1'b0; bus.if_req_in = 1'b0;
    check("latency", 32'(lat), (is_ls && we) ? 32'(n + 1) : 32'(n + 2));
    check("other_done", 32'(other), 32'd0);
    exp_cnt = (is_ls && we) ? n : n + 1;
    check("addr_count", 32'(alog.size()), 32'(exp_cnt));
    bad = 0;
    for (int k = 0; k < alog.size() && k < exp_cnt; k++) begin
      ea = (addr + 17'((k < n) ? k : n - 1)) & AMASK;
      if (alog[k] !== ea) bad++;
    end
    check("addr_seq", 32'(bad), 32'd0);
    if (is_ls && we) begin
      bad = 0;
      for (int k = 0; k < n; k++) begin
        ea = (addr + 17'(k)) & AMASK;
        shadow[ea] = wd[8*k +: 8];
        if (ram[ea] !== wd[8*k +: 8]) bad++;
      end
      check("ram_bytes", 32'(bad), 32'd0);
    end else begin
      check("read_data", data, model_read(addr, n));
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  vec_t        vecs[$];
  logic [31:0] d;
  int          cyc, ls_cyc, if_cyc, ncnt;
  bit          ord[$];

  initial begin
    bus.flush_in = 0; bus.if_req_in = 0; bus.if_addr_in = '0; bus.ls_req_in = 0;
    bus.ls_we_in = 0; bus.ls_size_in = '0; bus.ls_addr_in = '0; bus.ls_wdata_in = '0;

    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_en", 32'(bus.ram_en_out), 32'd0);
    check("rst_rnw", 32'(bus.ram_r_nw_out), 32'd1);
    check("rst_addr", 32'(bus.ram_a_out), 32'd0);
    check("rst_outs", {bus.if_done_out, bus.ls_done_out, 30'd0} | bus.if_data_out | bus.ls_rdata_out
                      | 32'(bus.ram_d_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < 36; k++) poke((17'h1FFF0 + 17'(k)) & AMASK, 8'($urandom));
    poke(17'h1FFFE, 8'hEF); poke(17'h1FFFF, 8'hAB); poke(17'h00000, 8'hCD); poke(17'h00001, 8'h01);
    poke(17'h00104, 8'h11);
    for (int k = 0; k < 4; k++) poke(17'h00200 + 17'(k), 8'h99);

    vecs.push_back('{1, 1, 2'b10, 17'h00100, 32'h12345678, 32'h0});
    vecs.push_back('{1, 0, 2'b10, 17'h00100, 32'h0,        32'h12345678});
    vecs.push_back('{1, 0, 2'b01, 17'h1FFFF, 32'h0,        32'h0000CDAB});
    vecs.push_back('{1, 1, 2'b00, 17'h00105, 32'hFFFFFF5A, 32'h0});
    vecs.push_back('{1, 0, 2'b00, 17'h00105, 32'h0,        32'h0000005A});
    vecs.push_back('{1, 1, 2'b01, 17'h00106, 32'hFFFFBEEF, 32'h0});
    vecs.push_back('{1, 0, 2'b11, 17'h00104, 32'h0,        32'hBEEF5A11});
    vecs.push_back('{0, 0, 2'b10, 17'h00100, 32'h0,        32'h12345678});
    vecs.push_back('{0, 0, 2'b10, 17'h1FFFE, 32'h0,        32'h01CDABEF});
    foreach (vecs[i]) begin
      run_txn(vecs[i].is_ls, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, d);
      if (!(vecs[i].is_ls && vecs[i].we)) check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
    end

    // Simultaneous requests straight after reset: LS first, IF the cycle after LS done.
    do_reset();
    @(negedge clk);
    bus.ls_req_in = 1; bus.ls_we_in = 0; bus.ls_size_in = 2'b10; bus.ls_addr_in = 17'h00100;
    bus.if_req_in = 1; bus.if_addr_in = 17'h1FFFE;
    ls_cyc = 0; if_cyc = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus.ls_done_out) begin ls_cyc = cyc; check("arb_ls_data", bus.ls_rdata_out, 32'h12345678); bus.ls_req_in = 0; end
      if (bus.if_done_out) begin if_cyc = cyc; check("arb_if_data", bus.if_data_out, 32'h01CDABEF); bus.if_req_in = 0; break; end
    end
    bus.ls_req_in = 0; bus.if_req_in = 0;
    check("arb_ls_cycle", 32'(ls_cyc), 32'd6);
    check("arb_if_cycle", 32'(if_cyc), 32'd13);

    // Both ports requesting continuously.
    @(negedge clk);
    bus.ls_req_in = 1; bus.if_req_in = 1;
    for (cyc = 0; cyc < 80 && ord.size() < 4; cyc++) begin
      @(negedge clk);
      if (bus.ls_done_out) ord.push_back(1'b1);
      if (bus.if_done_out) ord.push_back(1'b0);
    end
    bus.ls_req_in = 0; bus.if_req_in = 0;
    check("cont_grants", 32'(ord.size()), 32'd4);
    for (int k = 0; k < ord.size(); k++) begin
`ifdef MEM_CTRL_RR_EN
      check($sformatf("cont_order%0d", k), 32'(ord[k]), 32'((k % 2) == 0));
`else
      check($sformatf("cont_order%0d", k), 32'(ord[k]), 32'd1);
`endif
    end
    repeat (8) @(negedge clk);

    // Flush while IF is in its second byte cycle.
    @(negedge clk);
    bus.if_req_in = 1; bus.if_addr_in = 17'h00100;
    @(negedge clk);
    check("pre_flush_en", 32'(bus.ram_en_out), 32'd1);
    @(negedge clk);
    bus.flush_in = 1; bus.if_req_in = 0;
    #1 check("flush_en_drop", 32'(bus.ram_en_out), 32'd0);
    @(negedge clk);
    bus.flush_in = 0;
    check("flush_idle_en", 32'(bus.ram_en_out), 32'd0);
    ncnt = 0;
    repeat (10) begin @(negedge clk); if (bus.if_done_out || bus.ram_en_out) ncnt++; end
    check("flush_no_done", 32'(ncnt), 32'd0);
    run_txn(1, 0, 2'b10, 17'h00104, 32'h0, d);

    // Flush in IDLE masks an IF request for that cycle only.
    @(negedge clk);
    bus.flush_in = 1; bus.if_req_in = 1; bus.if_addr_in = 17'h00100;
    @(negedge clk);
    check("idle_flush_hold", 32'(bus.ram_en_out), 32'd0);
    bus.flush_in = 0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (bus.if_done_out) break;
    end
    bus.if_req_in = 0;
    check("idle_flush_lat", 32'(cyc), 32'd6);
    check("idle_flush_data", bus.if_data_out, 32'h12345678);

    // Reset while the second byte of a word write is on the pins.
    @(negedge clk);
    bus.ls_req_in = 1; bus.ls_we_in = 1; bus.ls_size_in = 2'b10;
    bus.ls_addr_in = 17'h00200; bus.ls_wdata_in = 32'hA1B2C3D4;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0; bus.ls_req_in = 0;
    #1 check("rst_mid_en", 32'(bus.ram_en_out), 32'd0);
    check("rst_mid_rnw", 32'(bus.ram_r_nw_out), 32'd1);
    @(negedge clk); rst_n = 1;
    shadow[17'h00200] = 8'hD4;
    check("rst_mid_ram", {ram[17'h00203], ram[17'h00202], ram[17'h00201], ram[17'h00200]}, 32'h999999D4);
    @(negedge clk);
    check("rst_mid_idle", {31'd0, bus.ram_en_out} | {31'd0, bus.ls_done_out}, 32'd0);
    run_txn(1, 0, 2'b10, 17'h00200, 32'h0, d);

    // Random traffic in a window straddling the address wrap.
    for (int t = 0; t < 40; t++) begin
      bit          ls, we;
      logic [16:0] a;
      ls = ($urandom % 3) != 0;
      we = ls && ($urandom % 2);
      a  = (17'h1FFF0 + 17'($urandom_range(0, 31))) & AMASK;
      run_txn(ls, we, 2'($urandom), a, $urandom, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the CPU core and the 128 KB single-port synchronous on-board RAM. Arbitrates between the instruction-fetch port (IF, word reads) and the load/store port (LS, 1/2/4-byte reads and writes). Sequences each access as consecutive byte cycles on the 8-bit RAM port. Sits at the top of the core, driving the RAM's enable, read/write-select, address and data pins.

## Interface
- ADDR_WIDTH, 17, RAM byte-address width; all addresses wrap modulo 2^ADDR_WIDTH

- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- flush_in  input  1  abort any pending or in-flight IF read
- if_req_in  input  1  IF read request, held until if_done_out
- if_addr_in  input  ADDR_WIDTH  IF word address (byte address, no alignment required)
- if_done_out  output  1  one-cycle pulse, if_data_out valid
- if_data_out  output  32  fetched word, little-endian
- ls_req_in  input  1  LS request, held until ls_done_out
- ls_we_in  input  1  1 = write, 0 = read
- ls_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
- ls_addr_in  input  ADDR_WIDTH  LS byte address
- ls_wdata_in  input  32  write data; low N bytes used
- ls_done_out  output  1  one-cycle pulse; read data valid / write complete
- ls_rdata_out  output  32  read data, zero-extended
- ram_en_out  output  1  RAM chip enable
- ram_r_nw_out  output  1  1 = read, 0 = write
- ram_a_out  output  ADDR_WIDTH  RAM address
- ram_d_out  output  8  RAM write data
- ram_d_in  input  8  RAM read data; valid one cycle after the address, and only while ram_en_out is high

## Operation
- States: IDLE, ACCESS, WAIT (reads only), DONE.
- Requests are sampled only in IDLE.
  - One request: grant it.
  - Both requests: LS wins (see Configuration).
  - On grant, latch owner, address, size N (1/2/4), we and wdata; byte counter i = 0.
- ACCESS, N cycles: ram_en_out=1, ram_a_out = addr+i (wrapping), ram_r_nw_out = ~we, ram_d_out = wdata byte i.
  - From i ≥ 1, reads capture ram_d_in into result byte i-1.
  - After the last byte: reads → WAIT, writes → DONE.
- WAIT: ram_en_out=1, r_nw=1, address held; capture byte N-1; → DONE.
- DONE: pulse the owner's done for one cycle; data outputs hold until the next grant; → IDLE.
- Unused upper result bytes are 0.
- flush_in high in any cycle:
  - IF owns ACCESS/WAIT: abort immediately, drop ram_en_out, no if_done_out, → IDLE next cycle.
  - IDLE: IF request ignored that cycle.
  - LS transactions are never affected.
- ram_en_out is 0 in IDLE and DONE; ram_r_nw_out defaults to 1 whenever not writing.

## Timing
- Request sampled in IDLE at cycle S.
- Read: bytes issued S+1..S+N, done at S+N+2 (word read: S+6).
- Write: bytes written S+1..S+N, done at S+N+1 (word write: S+5).
- Back-to-back: next request is sampled the cycle after DONE. Requester updates or drops req on the DONE edge.
- Reset, asynchronous:
  - all outputs 0 except ram_r_nw_out=1;
  - state IDLE, last-grant = IF.
  - Mid-write reset stops writes within the reset cycle; bytes already written remain.
- Address wrap: 0x1FFFF+1 → 0x00000 (ADDR_WIDTH=17).

## Configuration
- MEM_CTRL_RR_EN defined: round-robin. When both request in IDLE, grant the port not granted last; a single requester is always granted.
- Undefined: fixed priority, LS over IF (IF may starve under continuous LS traffic).

## Structure
- Package mem_ctrl_pkg holds:
  - state enum (IDLE/ACCESS/WAIT/DONE);
  - owner enum (OWN_IF/OWN_LS);
  - size encodings and a size-to-byte-count constant function.
- Sub-module mem_ctrl_arb: request sampling, grant selection, last-grant register and MEM_CTRL_RR_EN logic.
- Byte sequencing stays in mem_ctrl.

## Test plan
- LS word write 0x12345678 at 0x00100, then LS word read at 0x00100.
  - Write: RAM bytes 0x100..0x103 = 78,56,34,12; ls_done_out at S+5.
  - Read: ls_rdata_out=0x12345678 at S+6.
- LS half read at 0x1FFFF with RAM[0x1FFFF]=0xAB, RAM[0]=0xCD → addresses 0x1FFFF then 0x00000; ls_rdata_out=0x0000CDAB.
- if_req_in and ls_req_in both rise in IDLE, fixed priority → LS served first, IF granted the cycle after ls_done_out; if_data_out correct.
- flush_in at S+2 of an IF read → no if_done_out, ram_en_out low from that cycle, IDLE next, subsequent LS request served normally.
- rst_n_in low during ACCESS of a word write at byte 1 → ram_en_out=0 immediately; only byte 0 written; state IDLE after release.
- With MEM_CTRL_RR_EN, both ports requesting continuously → grants alternate LS, IF, LS, IF…
